// File: rtl/palm_scan_controller_pkg.sv
// Shared types for the palm scan path: FSM state encoding, default frame geometry
// and the 8-bit coordinate type used by the segmentation and palm stages.
package palm_scan_controller_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitSof,
    StScan,
    StReport,
    StFail
  } state_e;

  localparam int unsigned ImgWDefault = 160;
  localparam int unsigned ImgHDefault = 120;

  typedef logic [7:0] coord_t;

endpackage

// File: rtl/palm_run_tracker.sv
// Horizontal run tracker: opens/extends/closes runs of hand pixels within a row and
// computes the width and palm height of the run closing on the current transfer.
module palm_run_tracker
  import palm_scan_controller_pkg::*;
#(
  parameter int unsigned MIN_WIDTH = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       restart,
  input  logic       pix_data,
  input  logic       last_col,
  input  logic [7:0] row,
  input  logic [7:0] col,
  input  logic       testing_switch,
  input  logic [7:0] palm_height_test,
  output logic       hit,
  output logic [7:0] run_r,
  output logic [7:0] run_sc,
  output logic [7:0] run_ec,
  output logic [7:0] width,
  output logic [7:0] height
);

  logic   open_q;
  coord_t r_q, sc_q, ec_q;
  logic   open_eff, close;
  coord_t r_d, sc_d, ec_d;

  // A start-of-frame pixel drops any run left open from the previous position.
  always_comb begin
    open_eff = open_q & ~restart;
    r_d      = r_q;
    sc_d     = sc_q;
    ec_d     = ec_q;
    if (pix_data) begin
      if (!open_eff) begin
        r_d  = row;
        sc_d = col;
      end
      ec_d = col;
    end
    close = (open_eff & ~pix_data) | (pix_data & last_col);
  end

  assign run_r  = r_d;
  assign run_sc = sc_d;
  assign run_ec = ec_d;
  assign width  = ec_d - sc_d;
  assign hit    = step & close & (width > coord_t'(MIN_WIDTH));
  assign height = testing_switch ? palm_height_test : width + (width >> 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      open_q <= 1'b0;
      r_q    <= '0;
      sc_q   <= '0;
      ec_q   <= '0;
    end else if (step) begin
      open_q <= pix_data & ~last_col;
      r_q    <= r_d;
      sc_q   <= sc_d;
      ec_q   <= ec_d;
    end
  end

endmodule

// File: rtl/palm_scan_controller.sv
// Palm search sequencer: arms on start, syncs to SOF, stops at the first qualifying run
// and reports it over a valid/ready handshake. Optional stall timeout: PALM_SCAN_TIMEOUT_EN.
module palm_scan_controller
  import palm_scan_controller_pkg::*;
#(
  parameter int unsigned IMG_W     = ImgWDefault,
  parameter int unsigned IMG_H     = ImgHDefault,
  parameter int unsigned MIN_WIDTH = 17
`ifdef PALM_SCAN_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 4095
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       pix_valid,
  output logic       pix_ready,
  input  logic       pix_data,
  input  logic       pix_sof,
  input  logic       testing_switch,
  input  logic [7:0] palm_height_test,
  output logic       busy,
`ifdef PALM_SCAN_TIMEOUT_EN
  output logic       timeout,
`endif
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_found,
  output logic [7:0] start_r,
  output logic [7:0] start_c,
  output logic [7:0] end_r,
  output logic [7:0] end_c,
  output logic [7:0] palm_width,
  output logic [7:0] palm_height
);

  localparam coord_t LastCol = coord_t'(IMG_W - 1);
  localparam coord_t LastRow = coord_t'(IMG_H - 1);

  state_e state_q;
  coord_t row_q, col_q, row_eff, col_eff;
  logic   xfer, step, last_col, last_pix, tmo_hit;
  logic   run_hit;
  logic [7:0] run_r, run_sc, run_ec, run_w, run_h;

  assign pix_ready = (state_q == StWaitSof) || (state_q == StScan);
  assign busy      = (state_q != StIdle);
  assign xfer      = pix_valid & pix_ready;
  // In WAIT_SOF only the SOF pixel is processed; everything else is dropped.
  assign step      = xfer & ~abort & ((state_q == StScan) | pix_sof);
  assign row_eff   = pix_sof ? '0 : row_q;
  assign col_eff   = pix_sof ? '0 : col_q;
  assign last_col  = (col_eff == LastCol);
  assign last_pix  = last_col && (row_eff == LastRow);

  palm_run_tracker #(
    .MIN_WIDTH(MIN_WIDTH)
  ) u_run_tracker (
    .clk             (clk),
    .rst             (rst),
    .step            (step),
    .restart         (pix_sof),
    .pix_data        (pix_data),
    .last_col        (last_col),
    .row             (row_eff),
    .col             (col_eff),
    .testing_switch  (testing_switch),
    .palm_height_test(palm_height_test),
    .hit             (run_hit),
    .run_r           (run_r),
    .run_sc          (run_sc),
    .run_ec          (run_ec),
    .width           (run_w),
    .height          (run_h)
  );

`ifdef PALM_SCAN_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  logic [TmoW-1:0] tmo_cnt_q;

  assign tmo_hit = pix_ready && !xfer && (tmo_cnt_q == TmoW'(TIMEOUT_CYC - 1));

  // Outside WAIT_SOF/SCAN the counter sits at zero, so state entry starts it fresh.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q <= '0;
    end else if (!pix_ready || xfer || tmo_hit || abort) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      row_q       <= '0;
      col_q       <= '0;
      res_valid   <= 1'b0;
      res_found   <= 1'b0;
      start_r     <= '0;
      start_c     <= '0;
      end_r       <= '0;
      end_c       <= '0;
      palm_width  <= '0;
      palm_height <= '0;
`ifdef PALM_SCAN_TIMEOUT_EN
      timeout     <= 1'b0;
`endif
    end else begin
      if (step) begin
        col_q <= last_col ? '0 : col_eff + 8'd1;
        row_q <= last_col ? row_eff + 8'd1 : row_eff;
      end
      if (abort) begin
        state_q   <= StIdle;
        res_valid <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              state_q <= StWaitSof;
`ifdef PALM_SCAN_TIMEOUT_EN
              timeout <= 1'b0;
`endif
            end
          end
          StWaitSof, StScan: begin
            if (step && run_hit) begin
              state_q     <= StReport;
              res_valid   <= 1'b1;
              res_found   <= 1'b1;
              start_r     <= run_r;
              end_r       <= run_r;
              start_c     <= run_sc;
              end_c       <= run_ec;
              palm_width  <= run_w;
              palm_height <= run_h;
            end else if ((step && last_pix) || tmo_hit) begin
              state_q     <= StFail;
              res_valid   <= 1'b1;
              res_found   <= 1'b0;
              start_r     <= '0;
              end_r       <= '0;
              start_c     <= '0;
              end_c       <= '0;
              palm_width  <= '0;
              palm_height <= '0;
`ifdef PALM_SCAN_TIMEOUT_EN
              timeout     <= tmo_hit;
`endif
            end else if (step) begin
              state_q <= StScan;
            end
          end
          StReport, StFail: begin
            if (res_ready) begin
              state_q   <= StIdle;
              res_valid <= 1'b0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_palm_scan_controller.sv
// Directed bench for palm_scan_controller: table of whole-frame vectors plus hand-written
// restart, abort, reset and (with PALM_SCAN_TIMEOUT_EN) stall-timeout sequences.
module tb_palm_scan_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, abort = 1'b0;
  logic       pix_valid = 1'b0, pix_data = 1'b0, pix_sof = 1'b0;
  logic       testing_switch = 1'b0, res_ready = 1'b0;
  logic [7:0] palm_height_test = 8'd0;
  logic       pix_ready, busy, res_valid, res_found;
  logic [7:0] start_r, start_c, end_r, end_c, palm_width, palm_height;
`ifdef PALM_SCAN_TIMEOUT_EN
  logic       timeout;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         frame;
    logic       ts;
    logic [7:0] pht;
    logic       early;
    int         hold;
    int         close;
    logic       found;
    int         sr, sc, er, ec, w, h;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  palm_scan_controller dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .abort           (abort),
    .pix_valid       (pix_valid),
    .pix_ready       (pix_ready),
    .pix_data        (pix_data),
    .pix_sof         (pix_sof),
    .testing_switch  (testing_switch),
    .palm_height_test(palm_height_test),
    .busy            (busy),
`ifdef PALM_SCAN_TIMEOUT_EN
    .timeout         (timeout),
`endif
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_found       (res_found),
    .start_r         (start_r),
    .start_c         (start_c),
    .end_r           (end_r),
    .end_c           (end_c),
    .palm_width      (palm_width),
    .palm_height     (palm_height)
  );

  function automatic logic pix_at(input int f, input int r, input int c);
    case (f)
      0:       return (r == 40) && (c >= 30) && (c <= 55);
      1:       return ((r == 10) && (c >= 5) && (c <= 22)) || ((r == 12) && (c <= 18));
      2:       return (r == 3) && (c >= 141);
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // All tasks are entered and left on a falling edge.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic junk(input int n);
    for (int k = 0; k < n; k++) begin
      pix_valid = 1'b1;
      pix_sof   = 1'b0;
      pix_data  = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    pix_valid = 1'b0;
    pix_data  = 1'b0;
  endtask

  task automatic scan_frame(input int f, input int n, output int close);
    close = -1;
    for (int idx = 0; idx < n; idx++) begin
      pix_valid = 1'b1;
      pix_sof   = (idx == 0);
      pix_data  = pix_at(f, idx / 160, idx % 160);
      @(posedge clk);
      @(negedge clk);
      if (res_valid) begin
        close = idx;
        break;
      end
    end
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_data  = 1'b0;
  endtask

  task automatic consume(input string tag);
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_valid_drop"}, int'(res_valid), 0);
    check({tag, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    int ci;
    int cnt;
    string t;

    vecs[0] = '{0, 1'b0, 8'd0,  1'b1, 0, 6456,  1'b1, 40, 30, 40, 55, 25, 37};
    vecs[1] = '{0, 1'b1, 8'd90, 1'b0, 2, 6456,  1'b1, 40, 30, 40, 55, 25, 90};
    vecs[2] = '{1, 1'b0, 8'd0,  1'b0, 1, 1939,  1'b1, 12, 0,  12, 18, 18, 27};
    vecs[3] = '{2, 1'b0, 8'd0,  1'b0, 0, 639,   1'b1, 3, 141, 3, 159, 18, 27};
    vecs[4] = '{3, 1'b0, 8'd0,  1'b0, 5, 19199, 1'b0, 0, 0,   0, 0,   0,  0};

    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(res_valid), 0);
    check("rst_ready", int'(pix_ready), 0);
    check("rst_width", int'(palm_width), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      t = $sformatf("v%0d", i);
      testing_switch   = vecs[i].ts;
      palm_height_test = vecs[i].pht;
      res_ready        = vecs[i].early;
      pulse_start();
      check({t, "_armed"}, int'(pix_ready), 1);
      junk(3);
      scan_frame(vecs[i].frame, 19200, ci);
      check({t, "_close_idx"}, ci, vecs[i].close);
      check({t, "_found"}, int'(res_found), int'(vecs[i].found));
      check({t, "_start_r"}, int'(start_r), vecs[i].sr);
      check({t, "_start_c"}, int'(start_c), vecs[i].sc);
      check({t, "_end_r"}, int'(end_r), vecs[i].er);
      check({t, "_end_c"}, int'(end_c), vecs[i].ec);
      check({t, "_width"}, int'(palm_width), vecs[i].w);
      check({t, "_height"}, int'(palm_height), vecs[i].h);
      for (int k = 0; k < vecs[i].hold; k++) begin
        @(posedge clk);
        @(negedge clk);
        check({t, "_hold_valid"}, int'(res_valid), 1);
        check({t, "_hold_found"}, int'(res_found), int'(vecs[i].found));
        check({t, "_hold_height"}, int'(palm_height), vecs[i].h);
      end
      consume(t);
      testing_switch = 1'b0;
    end

    // SOF mid-run: the qualifying-width run open at the restart must be dropped.
    pulse_start();
    scan_frame(0, 40 * 160 + 51, ci);
    check("restart_no_early", ci, -1);
    scan_frame(0, 19200, ci);
    check("restart_close_idx", ci, 6456);
    check("restart_start_c", int'(start_c), 30);
    check("restart_width", int'(palm_width), 25);
    pulse_start();
    check("start_in_report_ignored", int'(res_valid), 1);
    consume("restart");

    // Abort mid-SCAN keeps the previous result fields.
    pulse_start();
    scan_frame(0, 1000, ci);
    check("abort_no_result", ci, -1);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(res_valid), 0);
    check("abort_ready", int'(pix_ready), 0);
    check("abort_keep_width", int'(palm_width), 25);
    check("abort_keep_found", int'(res_found), 1);

    // Asynchronous reset mid-frame.
    pulse_start();
    scan_frame(0, 3000, ci);
    rst = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_valid", int'(res_valid), 0);
    check("arst_width", int'(palm_width), 0);
    check("arst_found", int'(res_found), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

`ifdef PALM_SCAN_TIMEOUT_EN
    pulse_start();
    cnt = 0;
    while (!res_valid && cnt < 5000) begin
      @(posedge clk);
      @(negedge clk);
      cnt++;
    end
    check("tmo_stall_cycles", cnt, 4095);
    check("tmo_flag", int'(timeout), 1);
    check("tmo_found", int'(res_found), 0);
    consume("tmo");
    check("tmo_sticky", int'(timeout), 1);
    pulse_start();
    check("tmo_clear_on_start", int'(timeout), 0);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
`else
    cnt = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
